// File: rtl/rijndael_pkg.sv
// Shared Rijndael constants: forward/inverse S-box tables, SubBytes FSM states
// and a chunk-count helper. The inverse table is only referenced when RIJNDAEL_SUBBYTES_INV_EN is defined.
package rijndael_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} subbytes_state_e;

   function automatic int num_chunks(input int nb, input int nsbox);
      return (4 * nb) / nsbox;
   endfunction

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/rijndael_subbytes_iter_lane.sv
// One S-box lane: byte substitution, with the inverse table selectable per block
// only when RIJNDAEL_SUBBYTES_INV_EN is defined.
module rijndael_sbox_lane
   import rijndael_pkg::*;
(
   input  logic [7:0] data,
   input  logic       inv,
   output logic [7:0] sub
);

`ifdef RIJNDAEL_SUBBYTES_INV_EN
   assign sub = inv ? INV_SBOX[data] : SBOX[data];
`else
   logic unused_inv;
   assign unused_inv = inv;
   assign sub = SBOX[data];
`endif

endmodule

// File: rtl/rijndael_subbytes_iter.sv
// Iterative SubBytes: NSBOX lanes substitute one chunk per cycle while the work
// register rotates right. Inverse mode is built only with RIJNDAEL_SUBBYTES_INV_EN.
module rijndael_subbytes_iter
   import rijndael_pkg::*;
#(
   parameter int NB    = 4,
   parameter int NSBOX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_state,
   input  logic              in_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_state
);

   localparam int NUMBYTES  = 4 * NB;
   localparam int STATESIZE = 32 * NB;
   localparam int CHUNKS    = num_chunks(NB, NSBOX);
   localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int LANEW     = 8 * NSBOX;

   if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("rijndael_subbytes_iter: NB must be 4, 6 or 8");
   end
   if (NSBOX < 1 || (NUMBYTES % NSBOX) != 0) begin : g_bad_nsbox
      $error("rijndael_subbytes_iter: NSBOX must divide 4*NB");
   end

   subbytes_state_e state, state_nxt;
   logic [STATESIZE-1:0] work, work_rot;
   logic [CW-1:0]        count;
   logic [LANEW-1:0]     sub;
   logic                 accept, last_chunk, lane_inv;

   assign accept     = in_valid && in_ready;
   assign last_chunk = (count == CW'(CHUNKS - 1));
   assign out_state  = work;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: if (last_chunk) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            // Releasing the result frees the unit in the same cycle.
            in_ready  = out_ready;
            if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work  <= '0;
         count <= '0;
      end else if (accept) begin
         work  <= in_state;
         count <= '0;
      end else if (state == BUSY) begin
         work  <= work_rot;
         if (!last_chunk) count <= count + CW'(1);
      end
   end

`ifdef RIJNDAEL_SUBBYTES_INV_EN
   logic mode;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         mode <= 1'b0;
      else if (accept) mode <= in_inv;
   end
   assign lane_inv = mode;
`else
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
   assign lane_inv      = 1'b0;
`endif

   for (genvar g = 0; g < NSBOX; g++) begin : g_lane
      rijndael_sbox_lane u_lane (
         .data (work[8*g +: 8]),
         .inv  (lane_inv),
         .sub  (sub[8*g +: 8])
      );
   end

   // Substituted chunk enters at the top, so after CHUNKS steps byte order is restored.
   if (CHUNKS == 1) begin : g_rot_one
      assign work_rot = sub;
   end else begin : g_rot
      assign work_rot = {sub, work[STATESIZE-1:LANEW]};
   end

endmodule

// File: tb/tb_rijndael_subbytes_iter.sv
// Bench for rijndael_subbytes_iter: S-box reference derived from GF(2^8) arithmetic,
// directed vectors, backpressure, reset abort and randomized handshake traffic.
module tb_rijndael_subbytes_iter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
   logic [127:0] in_state = '0;
   logic         in_ready, out_valid;
   logic [127:0] out_state;

   logic         v32 = 1'b0, r32 = 1'b1, inv32 = 1'b0, rdy32, ov32;
   logic [255:0] is32 = '0, os32;
   logic         v1 = 1'b0, r1 = 1'b1, inv1 = 1'b0, rdy1, ov1;
   logic [255:0] is1 = '0, os1;

   rijndael_subbytes_iter #(.NB(4), .NSBOX(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state));

   rijndael_subbytes_iter #(.NB(8), .NSBOX(32)) dut_wide (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_state(is32),
      .in_inv(inv32), .out_valid(ov32), .out_ready(r32), .out_state(os32));

   rijndael_subbytes_iter #(.NB(8), .NSBOX(1)) dut_narrow (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_state(is1),
      .in_inv(inv1), .out_valid(ov1), .out_ready(r1), .out_state(os1));

   int checks = 0;
   int errors = 0;
   logic [7:0] fwd [256];
   logic [7:0] invt [256];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic hi;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         hi = a[7];
         a  = a << 1;
         if (hi) a ^= 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   // S(x) = affine(x^-1) in GF(2^8); inverse table is the permutation inverse.
   task automatic build_tables();
      logic [7:0] b, r, s;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         r = b;
         s = b;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
         end
         s ^= 8'h63;
         fwd[x]  = s;
         invt[s] = 8'(x);
      end
   endtask

   function automatic logic [255:0] model(input logic [255:0] st, input int nbytes, input bit inv);
      logic [255:0] r = '0;
      bit use_inv;
`ifdef RIJNDAEL_SUBBYTES_INV_EN
      use_inv = inv;
`else
      use_inv = 1'b0 & inv;
`endif
      for (int i = 0; i < nbytes; i++)
         r[8*i +: 8] = use_inv ? invt[st[8*i +: 8]] : fwd[st[8*i +: 8]];
      return r;
   endfunction

   // Offers one block on the main DUT with out_ready low and checks 4-cycle latency.
   task automatic run_block(input string tag, input logic [127:0] st, input bit inv, input logic [127:0] exp);
      @(negedge clk);
      in_valid = 1'b1; in_state = st; in_inv = inv; out_ready = 1'b0;
      #1 check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
      @(negedge clk);
      in_valid = 1'b0; in_state = ~st; in_inv = ~inv;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check({tag, "_out_valid"}, 256'(out_valid), 256'(i == 4));
      end
      check({tag, "_data"}, 256'(out_state), 256'(exp));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam int NRAND = 40;

   initial begin
      logic [127:0] r, q [$];
      logic [127:0] hold;
      logic [255:0] exp1;
      bit early, pend;
      int sent, got, cyc;

      build_tables();
      #2;
      check("reset_in_ready", 256'(in_ready), 256'(1));
      check("reset_out_valid", 256'(out_valid), 256'(0));
      check("reset_out_state", 256'(out_state), 256'(0));
      @(negedge clk);
      rst = 1'b0;

      run_block("fips_fwd", FIPS_IN, 1'b0, FIPS_OUT);

      hold = out_state;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 256'(out_valid), 256'(1));
         check("bp_out_state", 256'(out_state), 256'(hold));
         check("bp_in_ready", 256'(in_ready), 256'(0));
      end

      r = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b1; in_valid = 1'b1; in_state = r; in_inv = 1'b0;
      #1 check("b2b_in_ready", 256'(in_ready), 256'(1));
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         check("b2b_out_valid", 256'(out_valid), 256'(0));
         @(negedge clk);
      end
      check("b2b_done", 256'(out_valid), 256'(1));
      check("b2b_data", 256'(out_state), model(256'(r), 16, 1'b0));
      drain();

`ifdef RIJNDAEL_SUBBYTES_INV_EN
      run_block("fips_inv", FIPS_OUT, 1'b1, FIPS_IN);
      drain();
      run_block("inv_63", {16{8'h63}}, 1'b1, 128'h0);
      drain();
`endif

      @(negedge clk);
      in_valid = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_in_ready", 256'(in_ready), 256'(1));
      @(negedge clk);
      rst = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) early = 1'b1;
      end
      check("rst_no_output", 256'(early), 256'(0));
      run_block("post_rst", FIPS_IN, 1'b0, FIPS_OUT);
      drain();

      @(negedge clk);
      v32 = 1'b1; is32 = '0;
      @(negedge clk);
      v32 = 1'b0;
      check("wide_busy", 256'(ov32), 256'(0));
      @(negedge clk);
      check("wide_valid", 256'(ov32), 256'(1));
      check("wide_data", os32, {32{8'h63}});

      for (int i = 0; i < 32; i++) is1[8*i +: 8] = 8'(i);
      exp1 = model(is1, 32, 1'b0);
      v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      early = 1'b0;
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         if (ov1) early = 1'b1;
      end
      check("narrow_early", 256'(early), 256'(0));
      @(negedge clk);
      check("narrow_valid", 256'(ov1), 256'(1));
      check("narrow_data", os1, exp1);

      sent = 0; got = 0; cyc = 0; pend = 1'b0;
      while (got < NRAND && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (!pend && sent < NRAND && $urandom_range(0, 2) != 0) begin
            pend = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_inv = 1'($urandom_range(0, 1));
         end
         in_valid = pend;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("rand_spurious", 256'(1), 256'(0));
            else check("rand_data", 256'(out_state), 256'(q.pop_front()));
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(128'(model(256'(in_state), 16, in_inv)));
            pend = 1'b0;
            sent++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("rand_count", 256'(got), 256'(NRAND));
      check("rand_queue_empty", 256'(q.size()), 256'(0));
      early = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) early = 1'b1;
      end
      check("rand_no_extra", 256'(early), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
